// File: rtl/root_fanin_collector.sv
// ---------------------------------------------------------------------------
// root_fanin_collector
//   Round-robin fan-in of N_CHILD request streams into one registered output
//   slot. Each output beat carries the index of the child that produced it.
//   A wrapping counter records completed output handshakes for debug.
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    per-child request valid                 [N_CHILD]
//   in_data     per-child payload, child i at [i*DATA_W +: DATA_W]
//   in_ready    per-child accept, one-hot or zero       [N_CHILD]
//   out_valid   output slot holds a beat
//   out_ready   downstream accept
//   out_data    payload of the held beat                [DATA_W]
//   out_src     child index of the held beat            [SRC_W]
//   accept_cnt  completed output handshakes, wrapping   [CNT_W]
// ---------------------------------------------------------------------------
module root_fanin_collector #(
    parameter int unsigned N_CHILD = 5,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SRC_W   = $clog2(N_CHILD),
    parameter int unsigned CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CHILD-1:0]          in_valid,
    input  logic [N_CHILD*DATA_W-1:0]   in_data,
    output logic [N_CHILD-1:0]          in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [SRC_W-1:0]            out_src,
    output logic [CNT_W-1:0]            accept_cnt
);

    logic [SRC_W-1:0]  rr_ptr;
    logic              load_en;
    logic              found;
    logic [SRC_W-1:0]  grant_idx;
    logic [SRC_W-1:0]  next_ptr;
    logic [DATA_W-1:0] sel_data;
    logic              take;

    // The slot can take a new beat when empty or when draining this cycle.
    assign load_en = !out_valid || out_ready;

    // Scan from rr_ptr upward, wrapping modulo N_CHILD; the first valid
    // child in that order wins. The sum is one bit wider than the pointer
    // so the wrap subtraction cannot overflow.
    always_comb begin
        logic [SRC_W:0] sum;
        logic [SRC_W-1:0] idx;
        found     = 1'b0;
        grant_idx = '0;
        sum       = '0;
        idx       = '0;
        for (int unsigned k = 0; k < N_CHILD; k++) begin
            sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (sum >= (SRC_W+1)'(N_CHILD)) begin
                sum = sum - (SRC_W+1)'(N_CHILD);
            end
            idx = sum[SRC_W-1:0];
            if (!found && in_valid[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && found) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign take     = |in_ready;
    assign sel_data = in_data[grant_idx*DATA_W +: DATA_W];
    assign next_ptr = (grant_idx == SRC_W'(N_CHILD-1)) ? '0 : grant_idx + SRC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
            accept_cnt <= '0;
            rr_ptr     <= '0;
        end else begin
            if (out_valid && out_ready) begin
                accept_cnt <= accept_cnt + CNT_W'(1);
            end
            if (take) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_src   <= grant_idx;
                rr_ptr    <= next_ptr;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
